palette_arbiter: RTL and testbench
==================================

// Module: palette_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-read palette RAM between two requesters.
//  - Pixel renderer: one lookup per dot; has priority.
//  - CPU $2007 path: reads/writes in the $3F00-$3FFF window.
//  CPU accesses wait for an idle render slot; a starvation counter forces a slot.
//  Sits between the PPU pixel mux / register file and the palette RAM; palette mirroring stays inside the RAM.
// PARAMETERS
//  STARVE_MAX  8  max cycles a CPU request waits in PEND before it takes a render slot (>=1)
// PORTS
//  clk         in   1  PPU clock
//  rst         in   1  synchronous, active-high reset
//  rnd_valid   in   1  renderer lookup request this cycle
//  rnd_addr    in   5  renderer palette index
//  rnd_color   out  8  looked-up color, aligned with rnd_color_valid
//  rnd_color_valid out 1 registered copy of rnd_valid (1-cycle latency)
//  rnd_stall   out  1  pulse: previous-cycle render slot was taken by CPU; rnd_color repeats last color
//  gray        in   1  grayscale mode (PPUMASK bit 0); used only with PAL_GRAYSCALE_EN
//  cpu_req     in   1  CPU access strobe (1-cycle pulse)
//  cpu_we      in   1  1 = write, 0 = read; sampled with cpu_req
//  cpu_addr    in   5  CPU palette index; sampled with cpu_req
//  cpu_wdata   in   8  write data; sampled with cpu_req
//  cpu_ack     out  1  registered 1-cycle pulse: access complete
//  cpu_rdata   out  8  read data, {2'b00, pal[5:0]}; valid with cpu_ack on reads, held after
//  cpu_busy    out  1  state != IDLE
//  cpu_drop    out  1  registered pulse: cpu_req arrived while busy and was ignored
//  pal_addr    out  5  to palette RAM address
//  pal_wr      out  1  to palette RAM write enable
//  pal_wdata   out  8  to palette RAM write data
//  pal_rdata   in   8  from palette RAM; data for the previous cycle's pal_addr
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0, cpu_ack=0, cpu_drop=0, rnd_stall=0, rnd_color_valid=0.
//   Also on reset: last_color=0, cpu_rdata=0. Pending request is discarded and no ack is issued.
//  FSM: IDLE, PEND, RDATA.
//   IDLE: cpu_req -> latch we/addr/wdata, wait_cnt=0, go to PEND. The request is never issued in the same cycle.
//   PEND: grant = !rnd_valid | (wait_cnt == STARVE_MAX-1).
//    No grant: wait_cnt++.
//    Grant: drive pal_addr=latched addr, pal_wr=we, pal_wdata=wdata.
//     Write -> cpu_ack<=1 next edge, go to IDLE.
//     Read  -> go to RDATA.
//   RDATA: cpu_rdata <= {2'b00, pal_rdata[5:0]}, cpu_ack<=1, go to IDLE. Port is free for the renderer this cycle.
//  Port mux (combinational):
//   CPU grant > rnd_valid > idle. When idle: pal_addr=0, pal_wr=0.
//   pal_wr is high only on a write grant.
//  Render path:
//   served = rnd_valid & !grant; registered as served_q. rnd_color_valid <= rnd_valid.
//   rnd_color = served_q ? pal_rdata : last_color. When served_q, last_color <= pal_rdata.
//   rnd_stall <= rnd_valid & grant (forced grant only).
//  Boundaries:
//   cpu_req in PEND/RDATA: ignored, cpu_drop pulses, latched request unchanged.
//   cpu_req in the same cycle cpu_ack is high: state is IDLE, request accepted.
//   STARVE_MAX=1: grant on the first PEND cycle, regardless of rnd_valid.
//   Read-after-write to the same address returns the new data (write completes before the read is latched).
//  Latency:
//   Write, no render: req t0 -> grant t1 -> ack t2.
//   Read, no render: req t0 -> grant t1 -> RDATA t2 -> ack/rdata t3.
// CONFIGURATION
//  PAL_GRAYSCALE_EN defined: rnd_color is ANDed with 8'h30 when gray=1 (applies to served and held colors). cpu_rdata is unaffected.
//  Not defined: gray is ignored; rnd_color is the raw palette value.
// TESTING
//  1 Write, render idle: req we=1 addr=5'h03 wdata=8'h2A at t0 -> pal_wr=1, pal_addr=3 at t1; cpu_ack at t2; busy t1 only.
//  2 Read back: after 1, read addr 3 -> cpu_ack at t3, cpu_rdata=8'h2A; bench RAM 8'hFF at addr 3 -> cpu_rdata=8'h3F.
//  3 Starvation: rnd_valid held 1, CPU write at t0, STARVE_MAX=8 -> grant at t8.
//    Then rnd_stall=1 at t9 with rnd_color = color from t7; cpu_ack at t9.
//  4 Gap grant: rnd_valid 1 except t4 low, CPU read at t0 -> grant t4, cpu_ack t6, no rnd_stall.
//  5 Drop: CPU req at t0 and again at t1 -> cpu_drop at t2, exactly one ack, first request's addr used.
//  6 Reset mid-read: rst at RDATA cycle -> no cpu_ack, cpu_busy=0 next cycle, cpu_rdata=0.
//    With PAL_GRAYSCALE_EN, gray=1 and color 8'h2A -> rnd_color=8'h20.

Source files
------------

// File: rtl/palette_arbiter.sv
// Palette RAM port arbiter: renderer lookups have priority, CPU $2007 accesses wait for a free slot.
// Optional PAL_GRAYSCALE_EN masks renderer colors to the gray column while gray=1.
module palette_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rnd_valid,
  input  logic [4:0] rnd_addr,
  output logic [7:0] rnd_color,
  output logic       rnd_color_valid,
  output logic       rnd_stall,
  input  logic       gray,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic       cpu_busy,
  output logic       cpu_drop,
  output logic [4:0] pal_addr,
  output logic       pal_wr,
  output logic [7:0] pal_wdata,
  input  logic [7:0] pal_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             req_we_q, req_we_d;
  logic [4:0]       req_addr_q, req_addr_d;
  logic [7:0]       req_wdata_q, req_wdata_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             cpu_drop_q, cpu_drop_d;
  logic [7:0]       cpu_rdata_q, cpu_rdata_d;
  logic             grant_c;

  logic             served_q;
  logic             color_valid_q;
  logic             stall_q;
  logic [7:0]       last_color_q;
  logic [7:0]       color_raw_c;

  // CPU access FSM: latch, wait for a slot (or starve out), then return data
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_drop_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    grant_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          wait_d      = '0;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        cpu_drop_d = cpu_req;
        grant_c    = !rnd_valid || (wait_q == CNT_LAST);
        if (grant_c) begin
          cpu_ack_d = req_we_q;
          state_d   = req_we_q ? ST_IDLE : ST_RDATA;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_RDATA: begin
        cpu_drop_d  = cpu_req;
        cpu_rdata_d = {2'b00, pal_rdata[5:0]};
        cpu_ack_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_drop_q  <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_drop_q  <= cpu_drop_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // RAM port mux: CPU grant, then renderer, else parked at address 0
  always_comb begin
    pal_addr  = '0;
    pal_wr    = 1'b0;
    pal_wdata = '0;
    if (grant_c) begin
      pal_addr  = req_addr_q;
      pal_wr    = req_we_q;
      pal_wdata = req_wdata_q;
    end else if (rnd_valid) begin
      pal_addr = rnd_addr;
    end
  end

  // Render path: a stolen slot replays the last color and flags a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      served_q      <= 1'b0;
      color_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      last_color_q  <= '0;
    end else begin
      served_q      <= rnd_valid & ~grant_c;
      color_valid_q <= rnd_valid;
      stall_q       <= rnd_valid & grant_c;
      if (served_q) begin
        last_color_q <= pal_rdata;
      end
    end
  end

  assign color_raw_c = served_q ? pal_rdata : last_color_q;

`ifdef PAL_GRAYSCALE_EN
  assign rnd_color = gray ? (color_raw_c & 8'h30) : color_raw_c;
`else
  logic unused_gray;
  assign unused_gray = gray;
  assign rnd_color   = color_raw_c;
`endif

  assign rnd_color_valid = color_valid_q;
  assign rnd_stall       = stall_q;
  assign cpu_ack         = cpu_ack_q;
  assign cpu_drop        = cpu_drop_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with its own palette shadow.
module tb_palette_arbiter;
  localparam int unsigned SM = 8;

  logic       clk, rst;
  logic       rnd_valid, gray, cpu_req, cpu_we;
  logic [4:0] rnd_addr, cpu_addr, pal_addr;
  logic [7:0] cpu_wdata, rnd_color, cpu_rdata, pal_wdata, pal_rdata;
  logic       rnd_color_valid, rnd_stall, cpu_ack, cpu_busy, cpu_drop, pal_wr;

  logic [7:0] ram [32];
  logic       poke_en;
  logic [4:0] poke_addr;
  logic [7:0] poke_data;

  int checks = 0;
  int failures = 0;

  palette_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .rnd_valid(rnd_valid), .rnd_addr(rnd_addr), .rnd_color(rnd_color),
    .rnd_color_valid(rnd_color_valid), .rnd_stall(rnd_stall), .gray(gray),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_drop(cpu_drop),
    .pal_addr(pal_addr), .pal_wr(pal_wr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Palette RAM model: 1-cycle read, bench pokes only while the DUT is not writing
  always @(posedge clk) begin
    if (pal_wr) ram[pal_addr] <= pal_wdata;
    else if (poke_en) ram[poke_addr] <= poke_data;
    pal_rdata <= ram[pal_addr];
  end

  function automatic logic [7:0] shade(input logic [7:0] c, input logic g);
`ifdef PAL_GRAYSCALE_EN
    return g ? (c & 8'h30) : c;
`else
    return (g === 1'bx) ? c : c;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    rnd_valid = 0; rnd_addr = 0; gray = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    poke_en = 1; poke_addr = a; poke_data = d;
    step;
    poke_en = 0;
  endtask

  task automatic test_reset;
    rst = 1; poke_en = 0; poke_addr = 0; poke_data = 0;
    drive_idle;
    for (int i = 0; i < 32; i++) poke(5'(i), 8'($urandom));
    step;
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
    checks++; if (cpu_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", cpu_drop); end
    checks++; if (rnd_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", rnd_stall); end
    checks++; if (rnd_color_valid !== 1'b0) begin failures++; $display("FAIL reset_cvalid got=%b exp=0", rnd_color_valid); end
    checks++; if (cpu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cpu_busy); end
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); end
    checks++; if (rnd_color !== 8'h00) begin failures++; $display("FAIL reset_color got=%h exp=00", rnd_color); end
    checks++; if (pal_wr !== 1'b0 || pal_addr !== 5'd0) begin failures++; $display("FAIL reset_port got wr=%b addr=%h exp wr=0 addr=00", pal_wr, pal_addr); end
    rst = 0;
    step;
  endtask

  task automatic test_write;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h03; cpu_wdata = 8'h2A;
    #1;
    checks++; if (cpu_busy !== 1'b0) begin failures++; $display("FAIL wr_busy_t0 got=%b exp=0", cpu_busy); end
    step;
    cpu_req = 0; #1;
    checks++; if (pal_wr !== 1'b1 || pal_addr !== 5'h03 || pal_wdata !== 8'h2A) begin
      failures++; $display("FAIL wr_grant_t1 got wr=%b addr=%h data=%h exp 1/03/2a", pal_wr, pal_addr, pal_wdata); end
    checks++; if (cpu_busy !== 1'b1 || cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_t1 got busy=%b ack=%b exp 1/0", cpu_busy, cpu_ack); end
    step;
    checks++; if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0 || pal_wr !== 1'b0) begin
      failures++; $display("FAIL wr_t2 got ack=%b busy=%b wr=%b exp 1/0/0", cpu_ack, cpu_busy, pal_wr); end
    step;
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_t3_ack got=%b exp=0", cpu_ack); end
  endtask

  task automatic do_read3(input logic [7:0] exp, input string nm);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    step;
    cpu_req = 0; #1;
    checks++; if (pal_addr !== 5'h03 || pal_wr !== 1'b0) begin failures++; $display("FAIL %s_grant got addr=%h wr=%b exp 03/0", nm, pal_addr, pal_wr); end
    step;
    checks++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b1) begin failures++; $display("FAIL %s_t2 got ack=%b busy=%b exp 0/1", nm, cpu_ack, cpu_busy); end
    step;
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== exp) begin failures++; $display("FAIL %s_t3 got ack=%b rdata=%h exp 1/%h", nm, cpu_ack, cpu_rdata, exp); end
    step;
  endtask

  task automatic test_read;
    do_read3(8'h2A, "rd_back");
    poke(5'h03, 8'hFF);
    do_read3(8'h3F, "rd_mask");
  endtask

  task automatic test_starve;
    logic [7:0] col7;
    col7 = 0;
    for (int t = 0; t <= 9; t++) begin
      rnd_valid = 1; rnd_addr = 5'($urandom);
      cpu_req = (t == 0); cpu_we = 1; cpu_addr = 5'h07; cpu_wdata = 8'h11;
      #1;
      if (t >= 1 && t <= 7) begin
        checks++; if (pal_wr !== 1'b0 || pal_addr !== rnd_addr) begin
          failures++; $display("FAIL starve_wait t=%0d got wr=%b addr=%h exp 0/%h", t, pal_wr, pal_addr, rnd_addr); end
      end
      if (t == 7) col7 = ram[rnd_addr];
      if (t == 8) begin
        checks++; if (pal_wr !== 1'b1 || pal_addr !== 5'h07) begin failures++; $display("FAIL starve_grant got wr=%b addr=%h exp 1/07", pal_wr, pal_addr); end
        checks++; if (rnd_color !== shade(col7, gray) || rnd_stall !== 1'b0 || cpu_ack !== 1'b0) begin
          failures++; $display("FAIL starve_t8 got color=%h stall=%b ack=%b exp %h/0/0", rnd_color, rnd_stall, cpu_ack, shade(col7, gray)); end
      end
      if (t == 9) begin
        checks++; if (rnd_stall !== 1'b1 || rnd_color !== shade(col7, gray) || cpu_ack !== 1'b1) begin
          failures++; $display("FAIL starve_t9 got stall=%b color=%h ack=%b exp 1/%h/1", rnd_stall, rnd_color, cpu_ack, shade(col7, gray)); end
      end
      step;
    end
    drive_idle;
    step;
  endtask

  task automatic test_gap;
    int stalls;
    stalls = 0;
    for (int t = 0; t <= 7; t++) begin
      rnd_valid = (t != 4); rnd_addr = 5'($urandom);
      cpu_req = (t == 0); cpu_we = 0; cpu_addr = 5'h03;
      #1;
      stalls += int'(rnd_stall);
      if (t >= 1 && t <= 3) begin
        checks++; if (pal_addr !== rnd_addr) begin failures++; $display("FAIL gap_render t=%0d got=%h exp=%h", t, pal_addr, rnd_addr); end
      end
      if (t == 4) begin
        checks++; if (pal_addr !== 5'h03 || pal_wr !== 1'b0) begin failures++; $display("FAIL gap_grant got addr=%h wr=%b exp 03/0", pal_addr, pal_wr); end
      end
      if (t == 5) begin
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL gap_t5_ack got=%b exp=0", cpu_ack); end
      end
      if (t == 6) begin
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3F) begin failures++; $display("FAIL gap_t6 got ack=%b rdata=%h exp 1/3f", cpu_ack, cpu_rdata); end
      end
      step;
    end
    checks++; if (stalls != 0) begin failures++; $display("FAIL gap_stall got=%0d exp=0", stalls); end
    drive_idle;
    step;
  endtask

  task automatic test_drop;
    int acks, drops;
    logic [7:0] old10;
    acks = 0; drops = 0; old10 = ram[10];
    for (int t = 0; t <= 5; t++) begin
      cpu_req = (t <= 1); cpu_we = 1;
      cpu_addr = (t == 0) ? 5'd9 : 5'd10; cpu_wdata = (t == 0) ? 8'h55 : 8'h66;
      #1;
      acks += int'(cpu_ack);
      if (t >= 3) drops += int'(cpu_drop);
      if (t == 1) begin
        checks++; if (pal_wr !== 1'b1 || pal_addr !== 5'd9 || pal_wdata !== 8'h55) begin
          failures++; $display("FAIL drop_grant got wr=%b addr=%h data=%h exp 1/09/55", pal_wr, pal_addr, pal_wdata); end
      end
      if (t == 2) begin
        checks++; if (cpu_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", cpu_drop); end
      end
      step;
    end
    checks++; if (acks != 1) begin failures++; $display("FAIL drop_acks got=%0d exp=1", acks); end
    checks++; if (drops != 0) begin failures++; $display("FAIL drop_extra got=%0d exp=0", drops); end
    checks++; if (ram[9] !== 8'h55 || ram[10] !== old10) begin
      failures++; $display("FAIL drop_ram got r9=%h r10=%h exp 55/%h", ram[9], ram[10], old10); end
    drive_idle;
  endtask

  task automatic test_ack_req;
    for (int t = 0; t <= 5; t++) begin
      cpu_req = (t == 0 || t == 2); cpu_we = (t == 0);
      cpu_addr = 5'd12; cpu_wdata = 8'hE5;
      #1;
      if (t == 2) begin
        checks++; if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0) begin failures++; $display("FAIL ackreq_t2 got ack=%b busy=%b exp 1/0", cpu_ack, cpu_busy); end
      end
      if (t == 3) begin
        checks++; if (pal_addr !== 5'd12 || pal_wr !== 1'b0) begin failures++; $display("FAIL ackreq_grant got addr=%h wr=%b exp 0c/0", pal_addr, pal_wr); end
      end
      if (t == 5) begin
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h25) begin failures++; $display("FAIL ackreq_raw got ack=%b rdata=%h exp 1/25", cpu_ack, cpu_rdata); end
      end
      step;
    end
    drive_idle;
  endtask

  task automatic test_reset_mid_read;
    poke(5'd1, 8'h2A);
    rnd_valid = 1; rnd_addr = 5'd1; gray = 1;
    step;
    rnd_valid = 0; #1;
    checks++; if (rnd_color !== shade(8'h2A, 1'b1)) begin failures++; $display("FAIL gray_color got=%h exp=%h", rnd_color, shade(8'h2A, 1'b1)); end
    gray = 0;
    for (int t = 0; t <= 3; t++) begin
      cpu_req = (t == 0); cpu_we = 0; cpu_addr = 5'd12;
      rst = (t == 2);
      #1;
      if (t == 3) begin
        checks++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 8'h00) begin
          failures++; $display("FAIL rst_mid got ack=%b busy=%b rdata=%h exp 0/0/00", cpu_ack, cpu_busy, cpu_rdata); end
        checks++; if (rnd_color !== 8'h00 || rnd_color_valid !== 1'b0) begin
          failures++; $display("FAIL rst_mid_color got color=%h valid=%b exp 00/0", rnd_color, rnd_color_valid); end
      end
      step;
    end
    drive_idle;
  endtask

  // Reference: a pending request ages one per cycle; it owns the port when the
  // renderer is idle or once it has waited SM cycles. Reads return a cycle later.
  task automatic test_random;
    logic [7:0] exp_mem [32];
    logic pend, rd, p_we, g, served;
    logic [4:0] p_addr;
    logic [7:0] p_wdata, e_rdata, e_last;
    logic e_ack, e_drop, e_stall, e_cv, n_ack, n_drop, n_stall, n_rd;
    int p_t;
    rst = 1; drive_idle; step; step; rst = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = ram[i];
    pend = 0; rd = 0; p_we = 0; p_addr = 0; p_wdata = 0; p_t = 0;
    e_rdata = 0; e_last = 0; e_ack = 0; e_drop = 0; e_stall = 0; e_cv = 0;
    for (int c = 0; c < 1500; c++) begin
      step;
      checks++; if (cpu_ack !== e_ack || cpu_drop !== e_drop || cpu_busy !== (pend | rd)) begin
        failures++; $display("FAIL rand_cpu c=%0d got ack=%b drop=%b busy=%b exp %b/%b/%b", c, cpu_ack, cpu_drop, cpu_busy, e_ack, e_drop, pend | rd); end
      checks++; if (cpu_rdata !== e_rdata) begin failures++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, cpu_rdata, e_rdata); end
      checks++; if (rnd_stall !== e_stall || rnd_color_valid !== e_cv) begin
        failures++; $display("FAIL rand_render c=%0d got stall=%b valid=%b exp %b/%b", c, rnd_stall, rnd_color_valid, e_stall, e_cv); end
      rnd_valid = ($urandom_range(0, 9) < 7); rnd_addr = 5'($urandom);
      gray = 1'($urandom);
      cpu_req = ($urandom_range(0, 3) == 0); cpu_we = 1'($urandom);
      cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
      #1;
      g = pend && (!rnd_valid || (c - p_t) == int'(SM));
      served = rnd_valid && !g;
      checks++; if (rnd_color !== shade(e_last, gray)) begin failures++; $display("FAIL rand_color c=%0d got=%h exp=%h", c, rnd_color, shade(e_last, gray)); end
      if (g) begin
        checks++; if (pal_addr !== p_addr || pal_wr !== p_we || (p_we && pal_wdata !== p_wdata)) begin
          failures++; $display("FAIL rand_cpu_port c=%0d got addr=%h wr=%b data=%h exp %h/%b/%h", c, pal_addr, pal_wr, pal_wdata, p_addr, p_we, p_wdata); end
      end else begin
        checks++; if (pal_wr !== 1'b0 || pal_addr !== (rnd_valid ? rnd_addr : 5'd0)) begin
          failures++; $display("FAIL rand_port c=%0d got addr=%h wr=%b exp %h/0", c, pal_addr, pal_wr, rnd_valid ? rnd_addr : 5'd0); end
      end
      n_ack = (g && p_we) || rd;
      n_drop = cpu_req && (pend || rd);
      n_stall = rnd_valid && g;
      if (rd) e_rdata = {2'b00, exp_mem[p_addr][5:0]};
      if (served) e_last = exp_mem[rnd_addr];
      if (g && p_we) exp_mem[p_addr] = p_wdata;
      n_rd = g && !p_we;
      if (cpu_req && !pend && !rd) begin
        pend = 1; p_we = cpu_we; p_addr = cpu_addr; p_wdata = cpu_wdata; p_t = c;
      end else if (g) begin
        pend = 0;
      end
      rd = n_rd;
      e_ack = n_ack; e_drop = n_drop; e_stall = n_stall; e_cv = rnd_valid;
    end
    drive_idle;
    step;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_starve;
    test_gap;
    test_drop;
    test_ack_req;
    test_reset_mid_read;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
